branch_predictor_gshare: RTL

- Parametrised successor to the IF-stage BHT/BTB pair: gshare direction predictor plus tagged, direct-mapped BTB, global history register (GHR) with misprediction recovery, and saturating performance counters.
- Lookup is combinational on the IF-stage PC. Tables update synchronously from EX-stage resolution.
- Supports 16-bit compressed instructions: PC bit 0 is always ignored.
- Sits between IMEM/decoder output and the next-PC mux.

---
 rtl/branch_predictor_gshare_if.sv | 34 +++
 rtl/branch_predictor_gshare.sv | 99 +++++++++
 2 files changed

// File: rtl/branch_predictor_gshare_if.sv
// Lookup / resolve / counter bundle between the IF/EX pipeline and the gshare predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_gshare_if #(
  parameter int GHR_W = 8,
  parameter int CNT_W = 32
);
  logic             lkp_valid;
  logic [31:0]      lkp_pc;
  logic             lkp_is_br;
  logic             pred_taken;
  logic             pred_hit;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_mispredict;
  logic [CNT_W-1:0] cnt_branches;
  logic [CNT_W-1:0] cnt_mispred;

  modport master (
    output lkp_valid, lkp_pc, lkp_is_br,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_mispredict,
    input  pred_taken, pred_hit, pred_target, pred_ghr, cnt_branches, cnt_mispred
  );

  modport slave (
    input  lkp_valid, lkp_pc, lkp_is_br,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_ghr, upd_mispredict,
    output pred_taken, pred_hit, pred_target, pred_ghr, cnt_branches, cnt_mispred
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// gshare direction predictor + tagged direct-mapped BTB + GHR with mispredict repair.
// Combinational lookup on the IF PC; tables written from EX resolution.
module branch_predictor_gshare #(
  parameter int BHT_IDX_W = 8,
  parameter int BTB_IDX_W = 6,
  parameter int GHR_W     = 8,
  parameter int CNT_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_gshare_if.slave bp
);
  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 31 - BTB_IDX_W;

  logic [BHT_N-1:0][1:0]       bht;
  logic [BTB_N-1:0]            btb_vld;
  logic [BTB_N-1:0][TAG_W-1:0] btb_tag;
  logic [BTB_N-1:0][31:0]      btb_tgt;
  logic [GHR_W-1:0]            ghr;
  logic [GHR_W-1:0]            ghr_spec;
  logic [GHR_W-1:0]            ghr_rep;
  logic [CNT_W-1:0]            cnt_br;
  logic [CNT_W-1:0]            cnt_mp;

  logic [BHT_IDX_W-1:0] lkp_bi, upd_bi;
  logic [BTB_IDX_W-1:0] lkp_ti, upd_ti;
  logic [TAG_W-1:0]     lkp_tag, upd_tag;
  logic                 upd_fix;

  // PC bit 0 never participates, so 16-bit aligned PCs get their own entries
  assign lkp_bi  = bp.lkp_pc[BHT_IDX_W:1] ^ BHT_IDX_W'(ghr);
  assign upd_bi  = bp.upd_pc[BHT_IDX_W:1] ^ BHT_IDX_W'(bp.upd_ghr);
  assign lkp_ti  = bp.lkp_pc[BTB_IDX_W:1];
  assign upd_ti  = bp.upd_pc[BTB_IDX_W:1];
  assign lkp_tag = bp.lkp_pc[31:BTB_IDX_W+1];
  assign upd_tag = bp.upd_pc[31:BTB_IDX_W+1];
  assign upd_fix = bp.upd_valid & bp.upd_mispredict;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lkp_pc[0], bp.upd_pc[0]};

  assign bp.pred_hit     = btb_vld[lkp_ti] && (btb_tag[lkp_ti] == lkp_tag);
  assign bp.pred_taken   = bp.lkp_valid & bp.lkp_is_br & bp.pred_hit & bht[lkp_bi][1];
  assign bp.pred_target  = bp.pred_hit ? btb_tgt[lkp_ti] : '0;
  assign bp.pred_ghr     = ghr;
  assign bp.cnt_branches = cnt_br;
  assign bp.cnt_mispred  = cnt_mp;

  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_spec = bp.pred_taken;
      assign ghr_rep  = bp.upd_taken;
    end else begin : g_ghrn
      assign ghr_spec = {ghr[GHR_W-2:0], bp.pred_taken};
      assign ghr_rep  = {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
    end
  endgenerate

  // Repair from EX outranks the speculative shift from IF in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ghr <= '0;
    else if (upd_fix)                    ghr <= ghr_rep;
    else if (bp.lkp_valid & bp.lkp_is_br) ghr <= ghr_spec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht <= {BHT_N{2'b01}};
    end else if (bp.upd_valid) begin
      if (bp.upd_taken && bht[upd_bi] != 2'b11)       bht[upd_bi] <= bht[upd_bi] + 2'd1;
      else if (!bp.upd_taken && bht[upd_bi] != 2'b00) bht[upd_bi] <= bht[upd_bi] - 2'd1;
    end
  end

  // Only taken branches allocate; an alias with another tag is simply overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld <= '0;
      btb_tag <= '0;
      btb_tgt <= '0;
    end else if (bp.upd_valid && bp.upd_taken) begin
      btb_vld[upd_ti] <= 1'b1;
      btb_tag[upd_ti] <= upd_tag;
      btb_tgt[upd_ti] <= bp.upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_br <= '0;
      cnt_mp <= '0;
    end else begin
      if (bp.upd_valid && cnt_br != '1) cnt_br <= cnt_br + 1'b1;
      if (upd_fix && cnt_mp != '1)      cnt_mp <= cnt_mp + 1'b1;
    end
  end
endmodule
